// File: rtl/osc_multi.sv
// osc_multi: phase-accumulator (DDS) oscillator, one instance per voice.
// Frequency in Hz is turned into a phase increment by a serial restoring
// divider, so no combinational divide sits in the sample path. Produces
// square/pulse, sawtooth or triangle samples in two's complement, and a wrap
// pulse once per period.
module osc_multi #(
    parameter int unsigned CLK_HZ = 1000000,
    parameter int unsigned FREQ_W = 12,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned SIG_W  = 16,
    parameter int unsigned DUTY_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [FREQ_W-1:0] freq,
    input  logic [1:0]        mode,
    input  logic [DUTY_W-1:0] duty,
    output logic [SIG_W-1:0]  sig,
    output logic              wrap,
    output logic              busy
);

    // Numerator is freq * 2^ACC_W; one quotient bit is resolved per cycle.
    localparam int unsigned NUM_W = FREQ_W + ACC_W;
    // Partial remainder stays below CLK_HZ, so one extra bit holds the shifted value.
    localparam int unsigned REM_W = $clog2(CLK_HZ) + 1;
    localparam int unsigned CNT_W = $clog2(NUM_W + 1);

    localparam logic [REM_W:0]   DIVISOR = (REM_W + 1)'(CLK_HZ);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_W - 1);

    // Symmetric full-scale levels for the pulse wave (+max and -max, never -2^(SIG_W-1)).
    localparam logic [SIG_W-1:0] SIG_POS = {1'b0, {(SIG_W - 1){1'b1}}};
    localparam logic [SIG_W-1:0] SIG_NEG = {1'b1, {(SIG_W - 2){1'b0}}, 1'b1};

    localparam logic [1:0] MODE_PULSE = 2'd0;
    localparam logic [1:0] MODE_SAW   = 2'd1;
    localparam logic [1:0] MODE_TRI   = 2'd2;

    typedef enum logic {
        S_IDLE,
        S_DIV
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [FREQ_W-1:0] freq_lat;
    logic [FREQ_W-1:0] freq_lat_nxt;
    logic [NUM_W-1:0]  num;
    logic [NUM_W-1:0]  num_nxt;
    logic [REM_W-1:0]  rem;
    logic [REM_W-1:0]  rem_nxt;
    logic [ACC_W-1:0]  quo;
    logic [ACC_W-1:0]  quo_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [ACC_W-1:0]  inc;
    logic [ACC_W-1:0]  inc_nxt;
    logic              busy_nxt;

    logic [REM_W:0]    rem_sh_c;
    logic              ge_c;

    logic [ACC_W-1:0]  phase;
    logic [ACC_W:0]    acc_sum_c;
    logic [SIG_W-1:0]  wave_c;
    logic [SIG_W-1:0]  p_top_c;
    logic [SIG_W-1:0]  t_c;
    logic [SIG_W-1:0]  tri_v_c;
    logic [DUTY_W-1:0] duty_cmp_c;

    // Divider state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            freq_lat <= '0;
            num      <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            inc      <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            freq_lat <= freq_lat_nxt;
            num      <= num_nxt;
            rem      <= rem_nxt;
            quo      <= quo_nxt;
            cnt      <= cnt_nxt;
            inc      <= inc_nxt;
            busy     <= busy_nxt;
        end
    end

    // Divider next-state: latch a new freq in IDLE, then restoring shift-subtract.
    always_comb begin
        state_nxt    = state;
        freq_lat_nxt = freq_lat;
        num_nxt      = num;
        rem_nxt      = rem;
        quo_nxt      = quo;
        cnt_nxt      = cnt;
        inc_nxt      = inc;
        busy_nxt     = busy;

        rem_sh_c = {rem, num[NUM_W-1]};
        ge_c     = (rem_sh_c >= DIVISOR);

        case (state)
            S_IDLE: begin
                if (freq != freq_lat) begin
                    freq_lat_nxt = freq;
                    num_nxt      = {freq, ACC_W'(0)};
                    rem_nxt      = '0;
                    quo_nxt      = '0;
                    cnt_nxt      = '0;
                    busy_nxt     = 1'b1;
                    state_nxt    = S_DIV;
                end
            end
            S_DIV: begin
                num_nxt = num << 1;
                rem_nxt = ge_c ? REM_W'(rem_sh_c - DIVISOR) : REM_W'(rem_sh_c);
                // Only the low ACC_W quotient bits are ever used, so older bits fall off.
                quo_nxt = ACC_W'({quo, ge_c});
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == LAST_STEP) begin
                    inc_nxt   = quo_nxt;
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Wave shaping from the current phase.
    always_comb begin
        acc_sum_c  = {1'b0, phase} + {1'b0, inc};
        p_top_c    = phase[ACC_W-1 -: SIG_W];
        t_c        = phase[ACC_W-2 -: SIG_W];
        duty_cmp_c = phase[ACC_W-1 -: DUTY_W];
        // Rising half uses the folded phase directly, falling half its complement.
        tri_v_c    = phase[ACC_W-1] ? ~t_c : t_c;
        wave_c     = '0;

        case (mode)
            MODE_PULSE: wave_c = (duty_cmp_c < duty) ? SIG_POS : SIG_NEG;
            MODE_SAW:   wave_c = {~p_top_c[SIG_W-1], p_top_c[SIG_W-2:0]};
            MODE_TRI:   wave_c = {~tri_v_c[SIG_W-1], tri_v_c[SIG_W-2:0]};
            default:    wave_c = '0;
        endcase
    end

    // Phase accumulator, wrap pulse and registered sample; gate low clears all three.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
            wrap  <= 1'b0;
            sig   <= '0;
        end else if (!en) begin
            phase <= '0;
            wrap  <= 1'b0;
            sig   <= '0;
        end else begin
            phase <= acc_sum_c[ACC_W-1:0];
            wrap  <= acc_sum_c[ACC_W];
            sig   <= wave_c;
        end
    end

endmodule

// File: tb/tb_osc_multi.sv
// tb_osc_multi: directed checks of osc_multi with default parameters.
// Sample index m counts posedges since en went high from phase 0;
// the sample seen after edge m is the wave of phase (m-1)*inc.
module tb_osc_multi;

    logic        clk;
    logic        rst;
    logic        en;
    logic [11:0] freq;
    logic [1:0]  mode;
    logic [7:0]  duty;
    logic [15:0] sig;
    logic        wrap;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    osc_multi dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .freq (freq),
        .mode (mode),
        .duty (duty),
        .sig  (sig),
        .wrap (wrap),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Request a new frequency with the gate low, time the divider, then enable.
    task automatic start_freq(input logic [11:0] f);
        int bcnt;
        bcnt = 0;
        en   = 1'b0;
        freq = f;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (busy) bcnt++;
            if (k == 1) check("busy_rise", 64'(busy), 64'd1);
            if (k == 2) check("gate_low_sig", 64'(sig), 64'd0);
        end
        check("busy_fall", 64'(busy), 64'd0);
        check("busy_len", 64'(bcnt), 64'd44);
        en = 1'b1;
    endtask

    initial begin
        int cnt_a, cnt_b, cnt_c, first_w, second_w, fifth_w, last_w, bad;
        logic [15:0] prev, d;

        rst = 1'b1; en = 1'b0; freq = '0; mode = 2'd0; duty = 8'd128;
        tick(); tick();
        check("rst_sig", 64'(sig), 64'd0);
        check("rst_wrap", 64'(wrap), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        // freq=0 out of reset: no division, static phase 0 -> pulse high level
        en = 1'b1; cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int m = 1; m <= 20; m++) begin
            tick();
            if (busy) cnt_a++;
            if (wrap) cnt_b++;
            if (sig != 16'h7FFF) cnt_c++;
        end
        check("f0_busy", 64'(cnt_a), 64'd0);
        check("f0_wrap", 64'(cnt_b), 64'd0);
        check("f0_sig", 64'(cnt_c), 64'd0);

        // 1000 Hz pulse, 50% duty: inc = 4294967
        start_freq(12'd1000);
        cnt_a = 0; cnt_b = 0; first_w = 0; second_w = 0;
        for (int m = 1; m <= 2100; m++) begin
            tick();
            if (m == 1)   check("p_m1", 64'(sig), 64'h7FFF);
            if (m == 501) check("p_m501", 64'(sig), 64'h7FFF);
            if (m == 502) check("p_m502", 64'(sig), 64'h8001);
            if (m <= 1000 && sig == 16'h7FFF) cnt_a++;
            if (wrap) begin
                cnt_b++;
                if (cnt_b == 1) first_w = m;
                if (cnt_b == 2) second_w = m;
            end
        end
        check("p_high_cnt", 64'(cnt_a), 64'd501);
        check("p_wrap_cnt", 64'(cnt_b), 64'd2);
        check("p_wrap1", 64'(first_w), 64'd1001);
        check("p_wrap2", 64'(second_w), 64'd2001);

        // duty=0 is constant low, effective on the next sample
        duty = 8'd0;
        tick();
        check("duty0", 64'(sig), 64'h8001);
        duty = 8'd128;

        // 440 Hz: inc = 1889785, wraps every 2272 or 2273 cycles
        start_freq(12'd440);
        cnt_b = 0; first_w = 0; fifth_w = 0; last_w = 0; bad = 0;
        for (int m = 1; m <= 11400; m++) begin
            tick();
            if (wrap) begin
                cnt_b++;
                if (cnt_b == 1) first_w = m;
                if (cnt_b == 5) fifth_w = m;
                if (cnt_b > 1 && (m - last_w) != 2272 && (m - last_w) != 2273) bad++;
                last_w = m;
            end
        end
        check("a_wrap_cnt", 64'(cnt_b), 64'd5);
        check("a_wrap1", 64'(first_w), 64'd2273);
        check("a_wrap5", 64'(fifth_w), 64'd11364);
        check("a_spacing", 64'(bad), 64'd0);

        // Async reset in the middle of a division clears outputs immediately
        freq = 12'd1000;
        for (int k = 1; k <= 10; k++) tick();
        check("div_running", 64'(busy), 64'd1);
        check("pre_rst_sig", 64'(sig == 16'h0000), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("arst_sig", 64'(sig), 64'd0);
        check("arst_wrap", 64'(wrap), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        tick();

        // 440 then 880 while busy: second division starts one cycle after the first ends
        rst = 1'b0; en = 1'b0; freq = 12'd440; cnt_a = 0;
        for (int k = 1; k <= 90; k++) begin
            tick();
            if (k == 10) freq = 12'd880;
            if (busy) cnt_a++;
            if (k == 45) check("chg_gap", 64'(busy), 64'd0);
            if (k == 46) check("chg_restart", 64'(busy), 64'd1);
        end
        check("chg_busy_end", 64'(busy), 64'd0);
        check("chg_busy_len", 64'(cnt_a), 64'd88);
        en = 1'b1; first_w = 0;
        for (int m = 1; m <= 1140; m++) begin
            tick();
            if (wrap && first_w == 0) first_w = m;
        end
        check("chg_wrap1", 64'(first_w), 64'd1137);

        // 250 Hz sawtooth: inc = 1073741
        mode = 2'd1;
        start_freq(12'd250);
        bad = 0; cnt_b = 0; first_w = 0; prev = '0;
        for (int m = 1; m <= 4002; m++) begin
            tick();
            if (m == 1)    check("s_m1", 64'(sig), 64'h8000);
            if (m == 2)    check("s_m2", 64'(sig), 64'h8010);
            if (m == 3)    check("s_m3", 64'(sig), 64'h8020);
            if (m == 4)    check("s_m4", 64'(sig), 64'h8031);
            if (m == 4001) check("s_m4001", 64'(sig), 64'h7FFF);
            if (m == 4002) check("s_m4002", 64'(sig), 64'h8010);
            if (m >= 2 && m <= 4001) begin
                d = sig - prev;
                if (d != 16'd16 && d != 16'd17) bad++;
            end
            prev = sig;
            if (wrap) begin
                cnt_b++;
                if (first_w == 0) first_w = m;
            end
        end
        check("s_step", 64'(bad), 64'd0);
        check("s_wrap_cnt", 64'(cnt_b), 64'd1);
        check("s_wrap1", 64'(first_w), 64'd4001);

        // Gate low mid-period, then triangle from phase 0
        en = 1'b0; mode = 2'd2;
        tick();
        check("gate_sig", 64'(sig), 64'd0);
        check("gate_wrap", 64'(wrap), 64'd0);
        en = 1'b1;
        for (int m = 1; m <= 2002; m++) begin
            tick();
            if (m == 1)    check("t_m1", 64'(sig), 64'h8000);
            if (m == 2)    check("t_m2", 64'(sig), 64'h8020);
            if (m == 2001) check("t_peak", 64'(sig), 64'h7FFF);
            if (m == 2002) check("t_fall", 64'(sig), 64'h7FDF);
        end

        // Silence: sample is zero but the accumulator still wraps
        mode = 2'd3; cnt_b = 0; cnt_c = 0;
        for (int m = 2003; m <= 4100; m++) begin
            tick();
            if (sig != 16'h0000) cnt_c++;
            if (wrap) cnt_b++;
        end
        check("q_sig", 64'(cnt_c), 64'd0);
        check("q_wrap", 64'(cnt_b), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
